// File: rtl/dbg_pkg.sv
// Shared definitions for the pipeline debug controller: command opcodes,
// response bytes, controller state encoding and byte-sender source select.
package dbg_pkg;

  localparam logic [7:0] CMD_REGS  = 8'h01;
  localparam logic [7:0] CMD_LATCH = 8'h02;
  localparam logic [7:0] CMD_MEM   = 8'h03;
  localparam logic [7:0] CMD_LOAD  = 8'h04;
  localparam logic [7:0] CMD_RUN   = 8'h05;
  localparam logic [7:0] CMD_HALT  = 8'h06;
  localparam logic [7:0] CMD_STEP  = 8'h07;
  localparam logic [7:0] CMD_BKPT  = 8'h08;
  localparam logic [7:0] CMD_CLRBK = 8'h09;

  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;
  localparam logic [7:0] RSP_BRK = 8'hB7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_GET_ARG, ST_WAIT_MEM, ST_LOAD, ST_SEND, ST_RUN, ST_STEP
  } state_t;

  typedef enum logic [1:0] {
    SRC_RESP, SRC_REGS, SRC_LATCH, SRC_MEM
  } src_t;

endpackage

// File: rtl/dbg_byte_sender.sv
// Streams i_count bytes, little-endian, from the selected source to the UART
// transmitter, one byte per start/done handshake; pulses o_done at the end.
// Ports: i_load starts a transfer using i_src/i_count (held stable by the
// caller), i_registers/i_latch/i_mem_data/i_resp are the byte sources,
// o_tx_data/o_tx_start/i_tx_done form the tx handshake.
module dbg_byte_sender
  import dbg_pkg::*;
#(
  parameter int unsigned SIZE          = 32,
  parameter int unsigned NUM_REGISTERS = 32,
  parameter int unsigned LATCH_WIDTH   = 136
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_load,
  input  src_t                          i_src,
  input  logic [15:0]                   i_count,
  input  logic [7:0]                    i_resp,
  input  logic [SIZE*NUM_REGISTERS-1:0] i_registers,
  input  logic [LATCH_WIDTH-1:0]        i_latch,
  input  logic [SIZE-1:0]               i_mem_data,
  input  logic                          i_tx_done,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_start,
  output logic                          o_done
);

  logic [15:0] idx;
  logic        active;
  logic        waiting;
  logic [18:0] sh;
  logic [7:0]  byte_c;

  assign sh = {idx, 3'b000};

  // Byte idx of the selected source.
  always_comb begin
    case (i_src)
      SRC_REGS:  byte_c = 8'(i_registers >> sh);
      SRC_LATCH: byte_c = 8'(i_latch >> sh);
      SRC_MEM:   byte_c = 8'(i_mem_data >> sh);
      default:   byte_c = i_resp;
    endcase
  end

  // Issue a byte, then hold until the transmitter reports it sent.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx        <= '0;
      active     <= 1'b0;
      waiting    <= 1'b0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      if (i_load) begin
        idx     <= '0;
        active  <= (i_count != 16'd0);
        waiting <= 1'b0;
        o_done  <= (i_count == 16'd0);
      end else if (active && !waiting) begin
        o_tx_data  <= byte_c;
        o_tx_start <= 1'b1;
        waiting    <= 1'b1;
      end else if (active && i_tx_done) begin
        waiting <= 1'b0;
        if (idx == i_count - 16'd1) begin
          active <= 1'b0;
          o_done <= 1'b1;
        end else begin
          idx <= idx + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/dbg_ctrl_uart.sv
// Pipeline debug controller: decodes UART byte commands, dumps register file,
// pipeline latches and data memory, loads instruction memory and gates the
// CPU through o_cpu_en (run, halt, N-cycle step, one PC breakpoint).
// Ports: i_rx_* received bytes; o_tx_*/i_tx_done tx handshake; i_registers,
// i_latches, i_pc, i_mem_data core observation; o_mem_addr memory debug read;
// o_imem_* instruction write port; o_cpu_en clock enable; o_halted status.
module dbg_ctrl_uart
  import dbg_pkg::*;
#(
  parameter int unsigned SIZE            = 32,
  parameter int unsigned NUM_REGISTERS   = 32,
  parameter int unsigned NUM_LATCHES     = 4,
  parameter int unsigned LATCH_WIDTH     = 136,
  parameter int unsigned MEM_ADDR_WIDTH  = 8,
  parameter int unsigned IMEM_ADDR_WIDTH = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset_n,
  input  logic [7:0]                      i_rx_data,
  input  logic                            i_rx_valid,
  output logic [7:0]                      o_tx_data,
  output logic                            o_tx_start,
  input  logic                            i_tx_done,
  input  logic [SIZE*NUM_REGISTERS-1:0]   i_registers,
  input  logic [NUM_LATCHES*LATCH_WIDTH-1:0] i_latches,
  input  logic [SIZE-1:0]                 i_pc,
  output logic [MEM_ADDR_WIDTH-1:0]       o_mem_addr,
  input  logic [SIZE-1:0]                 i_mem_data,
  output logic                            o_imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0]      o_imem_addr,
  output logic [SIZE-1:0]                 o_imem_data,
  output logic                            o_cpu_en,
  output logic                            o_halted
);

  localparam int unsigned WORD_BYTES  = SIZE / 8;
  localparam int unsigned REG_BYTES   = WORD_BYTES * NUM_REGISTERS;
  localparam int unsigned LATCH_BYTES = LATCH_WIDTH / 8;

  state_t            state;
  logic [7:0]        op;
  logic [1:0]        arg_cnt;
  logic [7:0]        load_n;
  logic [7:0]        load_k;
  logic [7:0]        byte_cnt;
  logic [SIZE-9:0]   word;
  logic [7:0]        step_cnt;
  logic [31:0]       bp_pc;
  logic              bp_en;
  logic              first;
  logic              ret_run;
  logic              snd_load;
  src_t              snd_src;
  logic [15:0]       snd_count;
  logic [7:0]        snd_resp;
  logic [7:0]        lat_ch;
  logic              snd_done;
  logic [LATCH_WIDTH-1:0] latch_sel;
  logic              run_c;
  logic              hit_c;

  assign latch_sel = LATCH_WIDTH'(i_latches >> (32'(lat_ch) * LATCH_WIDTH));

  // Breakpoint compare is masked on the first enabled cycle so a resume from
  // the breakpoint PC makes progress.
  assign run_c    = (state == ST_RUN) || (state == ST_STEP);
  assign hit_c    = bp_en && (i_pc == SIZE'(bp_pc)) && !first;
  assign o_cpu_en = run_c && !hit_c;

  dbg_byte_sender #(
    .SIZE(SIZE), .NUM_REGISTERS(NUM_REGISTERS), .LATCH_WIDTH(LATCH_WIDTH)
  ) u_sender (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_load(snd_load), .i_src(snd_src),
    .i_count(snd_count), .i_resp(snd_resp), .i_registers(i_registers),
    .i_latch(latch_sel), .i_mem_data(i_mem_data), .i_tx_done(i_tx_done),
    .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_done(snd_done)
  );

  // Command decoder and CPU control.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;      op <= '0;        arg_cnt <= '0;
      load_n <= '0;          load_k <= '0;    byte_cnt <= '0;
      word <= '0;            step_cnt <= '0;  bp_pc <= '0;
      bp_en <= 1'b0;         first <= 1'b0;   ret_run <= 1'b0;
      o_halted <= 1'b1;      snd_load <= 1'b0; snd_src <= SRC_RESP;
      snd_count <= '0;       snd_resp <= '0;  lat_ch <= '0;
      o_mem_addr <= '0;      o_imem_we <= 1'b0;
      o_imem_addr <= '0;     o_imem_data <= '0;
    end else begin
      snd_load  <= 1'b0;
      o_imem_we <= 1'b0;
      case (state)
        ST_IDLE: if (i_rx_valid) begin
          op      <= i_rx_data;
          arg_cnt <= '0;
          case (i_rx_data)
            CMD_REGS: begin
              snd_src <= SRC_REGS; snd_count <= 16'(REG_BYTES); snd_load <= 1'b1; state <= ST_SEND;
            end
            CMD_LATCH, CMD_MEM, CMD_LOAD, CMD_STEP, CMD_BKPT: state <= ST_GET_ARG;
            CMD_RUN: begin
              ret_run <= 1'b1;
              snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ACK; snd_load <= 1'b1; state <= ST_SEND;
            end
            CMD_HALT: begin
              snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ACK; snd_load <= 1'b1; state <= ST_SEND;
            end
            CMD_CLRBK: begin
              bp_en <= 1'b0;
              snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ACK; snd_load <= 1'b1; state <= ST_SEND;
            end
            default: begin
              snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ERR; snd_load <= 1'b1; state <= ST_SEND;
            end
          endcase
        end
        ST_GET_ARG: if (i_rx_valid) begin
          case (op)
            CMD_LATCH: begin
              snd_load <= 1'b1;
              state    <= ST_SEND;
              if (32'(i_rx_data) >= NUM_LATCHES) begin
                snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ERR;
              end else begin
                lat_ch <= i_rx_data; snd_src <= SRC_LATCH; snd_count <= 16'(LATCH_BYTES);
              end
            end
            CMD_MEM: begin
              o_mem_addr <= MEM_ADDR_WIDTH'(i_rx_data);
              state      <= ST_WAIT_MEM;
            end
            CMD_LOAD: begin
              if (i_rx_data == 8'd0) begin
                snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ACK; snd_load <= 1'b1; state <= ST_SEND;
              end else begin
                load_n <= i_rx_data; load_k <= '0; byte_cnt <= '0; state <= ST_LOAD;
              end
            end
            CMD_STEP: begin
              if (i_rx_data == 8'd0) begin
                snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ACK; snd_load <= 1'b1; state <= ST_SEND;
              end else begin
                step_cnt <= i_rx_data; first <= 1'b1; o_halted <= 1'b0; state <= ST_STEP;
              end
            end
            default: begin
              // Breakpoint PC arrives LSB first; shift in from the top.
              bp_pc   <= {i_rx_data, bp_pc[31:8]};
              arg_cnt <= arg_cnt + 2'd1;
              if (arg_cnt == 2'd3) begin
                bp_en <= 1'b1;
                snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ACK; snd_load <= 1'b1; state <= ST_SEND;
              end
            end
          endcase
        end
        ST_WAIT_MEM: begin
          snd_src <= SRC_MEM; snd_count <= 16'(WORD_BYTES); snd_load <= 1'b1; state <= ST_SEND;
        end
        ST_LOAD: if (i_rx_valid) begin
          word <= {i_rx_data, word[SIZE-9:8]};
          if (byte_cnt == 8'(WORD_BYTES - 1)) begin
            byte_cnt    <= '0;
            o_imem_we   <= 1'b1;
            o_imem_data <= {i_rx_data, word};
            o_imem_addr <= IMEM_ADDR_WIDTH'(load_k);
            load_k      <= load_k + 8'd1;
            if (load_k == load_n - 8'd1) begin
              snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ACK; snd_load <= 1'b1; state <= ST_SEND;
            end
          end else begin
            byte_cnt <= byte_cnt + 8'd1;
          end
        end
        ST_SEND: if (snd_done) begin
          state   <= ret_run ? ST_RUN : ST_IDLE;
          ret_run <= 1'b0;
          if (ret_run) begin
            o_halted <= 1'b0;
            first    <= 1'b1;
          end
        end
        ST_RUN: begin
          first <= 1'b0;
          // Breakpoint has priority over a HALT arriving in the same cycle.
          if (hit_c) begin
            o_halted <= 1'b1;
            snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_BRK; snd_load <= 1'b1; state <= ST_SEND;
          end else if (i_rx_valid && i_rx_data == CMD_HALT) begin
            o_halted <= 1'b1;
            snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ACK; snd_load <= 1'b1; state <= ST_SEND;
          end else if (i_rx_valid && (i_rx_data == CMD_REGS || i_rx_data == CMD_LATCH ||
                                      i_rx_data == CMD_MEM)) begin
            ret_run <= 1'b1;
            snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ERR; snd_load <= 1'b1; state <= ST_SEND;
          end
        end
        ST_STEP: begin
          first    <= 1'b0;
          step_cnt <= step_cnt - 8'd1;
          if (hit_c) begin
            o_halted <= 1'b1;
            snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_BRK; snd_load <= 1'b1; state <= ST_SEND;
          end else if (step_cnt == 8'd1) begin
            o_halted <= 1'b1;
            snd_src <= SRC_RESP; snd_count <= 16'd1; snd_resp <= RSP_ACK; snd_load <= 1'b1; state <= ST_SEND;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
